// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: IF stage with PC ownership, imem request issue and a
// DEPTH-entry instruction queue presented to ID.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr   instruction read request and address (= PC)
//   imem_rdata            read data, one cycle after an issued request
//   redirect_valid/_pc    branch/jump redirect resolved in ID
//   stallD                ID cannot accept the head entry this cycle
//   validD/instrD/pcplus4D head entry presented to the IF-ID boundary
//   count                 queue occupancy
module fetch_queue_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [WIDTH-1:0]           imem_addr,
   input  logic [WIDTH-1:0]           imem_rdata,
   input  logic                       redirect_valid,
   input  logic [WIDTH-1:0]           redirect_pc,
   input  logic                       stallD,
   output logic                       validD,
   output logic [WIDTH-1:0]           instrD,
   output logic [WIDTH-1:0]           pcplus4D,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]      DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] issue_pc_q, issue_pc_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             inflight_q, inflight_d;
   logic             squash_q, squash_d;
   logic [WIDTH-1:0] ent_instr_q [DEPTH];
   logic [WIDTH-1:0] ent_instr_d [DEPTH];
   logic [WIDTH-1:0] ent_pc_q [DEPTH];
   logic [WIDTH-1:0] ent_pc_d [DEPTH];

   logic [CW:0] occ;
   logic        enq;
   logic        deq;

   // The in-flight request counts toward occupancy so its response
   // always finds a free slot.
   assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign imem_req  = rst & ~redirect_valid & (occ < DEPTH_W);
   assign imem_addr = pc_q;

   assign validD   = (count_q != '0);
   assign instrD   = validD ? ent_instr_q[rptr_q] : '0;
   assign pcplus4D = validD ? ent_pc_q[rptr_q] + FOUR : '0;
   assign count    = count_q;

   assign deq = validD & ~stallD;
   assign enq = inflight_q & ~squash_q & ~redirect_valid;

   always_comb begin
      pc_d        = pc_q;
      issue_pc_d  = issue_pc_q;
      rptr_d      = rptr_q;
      wptr_d      = wptr_q;
      count_d     = count_q;
      inflight_d  = 1'b0;
      squash_d    = 1'b0;
      ent_instr_d = ent_instr_q;
      ent_pc_d    = ent_pc_q;
      if (redirect_valid) begin
         // Wrong-path state is dropped; a response still owed for a
         // pre-redirect request is discarded on arrival via squash.
         pc_d     = redirect_pc;
         rptr_d   = '0;
         wptr_d   = '0;
         count_d  = '0;
         squash_d = inflight_q;
      end else begin
         if (imem_req) begin
            pc_d       = pc_q + FOUR;
            issue_pc_d = pc_q;
            inflight_d = 1'b1;
         end
         if (enq) begin
            ent_instr_d[wptr_q] = imem_rdata;
            ent_pc_d[wptr_q]    = issue_pc_q;
            wptr_d              = wptr_q + PTR_ONE;
         end
         if (deq) begin
            rptr_d = rptr_q + PTR_ONE;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         issue_pc_q <= '0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_instr_q[i] <= '0;
            ent_pc_q[i]    <= '0;
         end
      end else begin
         pc_q        <= pc_d;
         issue_pc_q  <= issue_pc_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         squash_q    <= squash_d;
         ent_instr_q <= ent_instr_d;
         ent_pc_q    <= ent_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: scripted vectors, reset/wrap corner
// cases and a randomized run against a queue-based reference model.
module tb_fetch_queue_unit;

   localparam int DEPTH = 4;
   localparam logic [31:0] K = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stallD = 1'b0;
   logic        validD;
   logic [31:0] instrD;
   logic [31:0] pcplus4D;
   logic [2:0]  count;

   logic        rst_w = 1'b0;
   logic        req_w;
   logic [31:0] addr_w;
   logic [31:0] rdata_w = '0;
   logic        valid_w;
   logic [31:0] instr_w;
   logic [31:0] p4_w;
   logic [2:0]  count_w;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_queue_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stallD(stallD),
      .validD(validD), .instrD(instrD), .pcplus4D(pcplus4D),
      .count(count)
   );

   fetch_queue_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) dut_w (
      .clk(clk), .rst(rst_w),
      .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .stallD(1'b0),
      .validD(valid_w), .instrD(instr_w), .pcplus4D(p4_w),
      .count(count_w)
   );

   // Instruction memory: data is the address xor K, one cycle later.
   always @(posedge clk) begin
      imem_rdata <= imem_addr ^ K;
      rdata_w    <= addr_w ^ K;
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] p4;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vt[29];

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic        m_infl;
   logic [31:0] m_infl_pc;

   task automatic model_check(input string tag);
      logic        e_req;
      logic        e_valid;
      e_valid = (m_q.size() != 0);
      e_req   = !redirect_valid && (m_q.size() + int'(m_infl) < DEPTH);
      chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, e_req});
      chk({tag, "_addr"}, imem_addr, m_pc);
      chk({tag, "_valid"}, {31'b0, validD}, {31'b0, e_valid});
      chk({tag, "_count"}, {29'b0, count}, 32'(m_q.size()));
      chk({tag, "_instr"}, instrD, e_valid ? m_q[0] ^ K : 32'h0);
      chk({tag, "_pc4"}, pcplus4D, e_valid ? m_q[0] + 32'd4 : 32'h0);
   endtask

   task automatic model_step();
      logic e_req;
      e_req = !redirect_valid && (m_q.size() + int'(m_infl) < DEPTH);
      if (redirect_valid) begin
         m_q.delete();
         m_infl = 1'b0;
         m_pc   = redirect_pc;
      end else begin
         if (m_q.size() != 0 && !stallD) void'(m_q.pop_front());
         if (m_infl) m_q.push_back(m_infl_pc);
         m_infl = e_req;
         if (e_req) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
   endtask

   initial begin
      vt[0]  = '{0, 0, 0,      1, 32'h0,   0, 32'h0,   3'd0};
      vt[1]  = '{0, 0, 0,      1, 32'h4,   0, 32'h0,   3'd0};
      vt[2]  = '{0, 0, 0,      1, 32'h8,   1, 32'h4,   3'd1};
      vt[3]  = '{0, 0, 0,      1, 32'hC,   1, 32'h8,   3'd1};
      vt[4]  = '{1, 0, 0,      1, 32'h10,  1, 32'hC,   3'd1};
      vt[5]  = '{1, 0, 0,      1, 32'h14,  1, 32'hC,   3'd2};
      vt[6]  = '{1, 0, 0,      0, 32'h18,  1, 32'hC,   3'd3};
      for (int i = 7; i < 14; i++)
         vt[i] = '{1, 0, 0,    0, 32'h18,  1, 32'hC,   3'd4};
      vt[14] = '{0, 0, 0,      0, 32'h18,  1, 32'hC,   3'd4};
      vt[15] = '{0, 0, 0,      1, 32'h18,  1, 32'h10,  3'd3};
      vt[16] = '{0, 0, 0,      1, 32'h1C,  1, 32'h14,  3'd2};
      vt[17] = '{0, 0, 0,      1, 32'h20,  1, 32'h18,  3'd2};
      vt[18] = '{1, 0, 0,      1, 32'h24,  1, 32'h1C,  3'd2};
      vt[19] = '{0, 1, 32'h100, 0, 32'h28, 1, 32'h1C,  3'd3};
      vt[20] = '{0, 0, 0,      1, 32'h100, 0, 32'h0,   3'd0};
      vt[21] = '{0, 0, 0,      1, 32'h104, 0, 32'h0,   3'd0};
      vt[22] = '{0, 0, 0,      1, 32'h108, 1, 32'h104, 3'd1};
      vt[23] = '{0, 1, 32'h200, 0, 32'h10C, 1, 32'h108, 3'd1};
      vt[24] = '{0, 1, 32'h300, 0, 32'h200, 0, 32'h0,  3'd0};
      vt[25] = '{0, 0, 0,      1, 32'h300, 0, 32'h0,   3'd0};
      vt[26] = '{0, 0, 0,      1, 32'h304, 0, 32'h0,   3'd0};
      vt[27] = '{0, 0, 0,      1, 32'h308, 1, 32'h304, 3'd1};
      vt[28] = '{0, 0, 0,      1, 32'h30C, 1, 32'h308, 3'd1};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, validD}, 32'h0);
      chk("rst_instr", instrD, 32'h0);
      chk("rst_pc4", pcplus4D, 32'h0);
      chk("rst_count", {29'b0, count}, 32'h0);

      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         rst            = 1'b1;
         stallD         = vt[i].stall;
         redirect_valid = vt[i].redir;
         redirect_pc    = vt[i].rpc;
         #1;
         chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
         chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
         chk($sformatf("vec%0d_valid", i), {31'b0, validD}, {31'b0, vt[i].valid});
         chk($sformatf("vec%0d_pc4", i), pcplus4D, vt[i].p4);
         chk($sformatf("vec%0d_count", i), {29'b0, count}, {29'b0, vt[i].cnt});
         chk($sformatf("vec%0d_instr", i), instrD,
             vt[i].valid ? (vt[i].p4 - 32'd4) ^ K : 32'h0);
      end

      // Fill the queue under stall, then reset between clock edges.
      @(negedge clk);
      redirect_valid = 1'b0;
      stallD         = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("full_count", {29'b0, count}, 32'd4);
      #1;
      rst = 1'b0;
      #1;
      chk("async_valid", {31'b0, validD}, 32'h0);
      chk("async_instr", instrD, 32'h0);
      chk("async_pc4", pcplus4D, 32'h0);
      chk("async_count", {29'b0, count}, 32'h0);
      chk("async_req", {31'b0, imem_req}, 32'h0);
      @(negedge clk);
      rst    = 1'b1;
      stallD = 1'b0;
      #1;
      chk("rel_req", {31'b0, imem_req}, 32'h1);
      chk("rel_addr", imem_addr, 32'h0);
      chk("rel_valid", {31'b0, validD}, 32'h0);
      @(negedge clk);
      #1;
      chk("rel1_valid", {31'b0, validD}, 32'h0);
      @(negedge clk);
      #1;
      chk("rel2_valid", {31'b0, validD}, 32'h1);
      chk("rel2_pc4", pcplus4D, 32'h4);
      chk("rel2_instr", instrD, K);

      // PC wrap on the second instance.
      @(negedge clk);
      rst_w = 1'b1;
      #1;
      chk("wrap0_addr", addr_w, 32'hFFFFFFF8);
      chk("wrap0_req", {31'b0, req_w}, 32'h1);
      @(negedge clk);
      #1;
      chk("wrap1_addr", addr_w, 32'hFFFFFFFC);
      @(negedge clk);
      #1;
      chk("wrap2_addr", addr_w, 32'h0);
      chk("wrap2_pc4", p4_w, 32'hFFFFFFFC);
      chk("wrap2_instr", instr_w, 32'hFFFFFFF8 ^ K);
      @(negedge clk);
      #1;
      chk("wrap3_pc4", p4_w, 32'h0);
      chk("wrap3_instr", instr_w, 32'hFFFFFFFC ^ K);
      chk("wrap3_count", {29'b0, count_w}, 32'd1);

      // Randomized run against the reference model.
      @(negedge clk);
      rst = 1'b0;
      redirect_valid = 1'b0;
      stallD = 1'b0;
      m_pc = 32'h0;
      m_q.delete();
      m_infl = 1'b0;
      m_infl_pc = 32'h0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst            = 1'b1;
         stallD         = ($urandom % 3) == 0 || (c % 100 > 80);
         redirect_valid = ($urandom % 12) == 0;
         redirect_pc    = $urandom & 32'hFFFFFFFC;
         #1;
         model_check("rnd");
         model_step();
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation IF stage: owns the PC, issues instruction-memory reads and buffers returned instructions in a DEPTH-entry FIFO.
- Decouples fetch from ID so that ID stalls no longer freeze instruction memory.
- Presents instr/pcplus4/valid to the IF-ID boundary.
- Accepts branch/jump redirects resolved in ID and squashes all wrong-path state.

Parameters:
- WIDTH, 32, instruction and address width in bits.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  WIDTH  read address; equals PC register.
- imem_rdata  input  WIDTH  read data, valid exactly one cycle after an issued request.
- redirect_valid  input  1  branch/jump taken in ID.
- redirect_pc  input  WIDTH  redirect target.
- stallD  input  1  ID cannot accept an instruction this cycle.
- validD  output  1  head entry valid.
- instrD  output  WIDTH  head instruction.
- pcplus4D  output  WIDTH  head entry PC + 4.
- count  output  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC = RESET_PC.
  - Read and write pointers = 0; count = 0; inflight = 0; squash = 0.
  - validD = 0; instrD = 0; pcplus4D = 0.
  - imem_req = 0 while rst=0.
  - Reset asserted mid-operation discards queue and in-flight data immediately.
- Issue rule (combinational):
  - imem_req = rst & ~redirect_valid & (count + inflight < DEPTH).
  - The in-flight slot is reserved so a returning response always has space.
- On an issue edge:
  - PC <= PC + 4, wrapping modulo 2^WIDTH.
  - inflight <= 1; otherwise inflight <= 0.
- Response:
  - In the cycle after an issue, imem_rdata is captured into queue[wptr] with its PC (PC of the issue) unless squash = 1 or redirect_valid = 1.
  - wptr increments, wrapping at DEPTH.
- Dequeue:
  - validD = (count != 0).
  - instrD = queue[rptr].instr; pcplus4D = queue[rptr].pc + 4.
  - Outputs are driven from storage, not bypassed. When empty, instrD and pcplus4D hold 0.
  - Dequeue occurs when validD & ~stallD; rptr increments, wrapping.
- Count:
  - Simultaneous enqueue and dequeue leaves count unchanged, including at count = DEPTH-1 and at full.
  - Dequeue when empty is impossible by construction.
  - Enqueue when full is impossible by the issue rule.
- Redirect (redirect_valid = 1), edge at end of cycle t:
  - Pointers and count cleared; PC <= redirect_pc; squash <= inflight.
  - A dequeue in cycle t is still consumed by ID; the redirect has priority over any enqueue in cycle t.
  - The response arriving in t+1 from a pre-redirect request is dropped via squash; squash clears after that cycle.
  - First request at redirect_pc is issued in t+1, data enqueued at the edge ending t+2, validD = 1 in t+3.
  - Redirect penalty is 3 cycles, fixed.
- Back-to-back redirects:
  - The latest redirect wins.
  - Each redirect restarts the 3-cycle sequence.
- Steady state, no stalls:
  - One request per cycle; one instruction delivered per cycle.
  - Occupancy settles at 1.
- Sustained stallD:
  - The queue fills to DEPTH; imem_req drops when count + inflight = DEPTH.
  - No data is lost or duplicated.

Test Plan:
- Reset release, imem returns addr-derived data (rdata = addr ^ 0xA5A5A5A5), stallD = 0:
  - first imem_req in cycle 0 with addr 0x0.
  - validD in cycle 2 with instrD = 0xA5A5A5A5, pcplus4D = 0x4.
  - then addresses 0x4, 0x8… delivered one per cycle.
- Hold stallD = 1 for 10 cycles (DEPTH = 4):
  - count reaches 4; imem_req low once count + inflight = 4.
  - on release, instructions for 0x0, 0x4, 0x8, 0xC, 0x10 are delivered in order, none missing or repeated.
- Redirect in cycle t to 0x100 while count = 3 and inflight = 1:
  - count = 0 at t+1.
  - the stale response at t+1 is not enqueued.
  - validD = 1 at t+3 with pcplus4D = 0x104.
- Redirect in consecutive cycles to 0x200 then 0x300:
  - only 0x300-stream instructions appear; first valid 3 cycles after the second redirect.
- PC wrap: RESET_PC = 0xFFFFFFF8:
  - fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - pcplus4D for the 0xFFFFFFFC entry = 0x0.
- Assert rst low mid-stream, with the queue full and inflight = 1:
  - outputs zero immediately without a clock edge.
  - after release, fetch restarts at RESET_PC and no stale entries appear.
